hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the five-stage MIPS core. It generates stall and flush controls for the IFID, IDEXE, EXEMEM and MEMWB pipeline registers plus a PC hold, covering five sources: memory wait, multicycle execute operations (mult/div), load-use interlocks, taken-branch squash and optional fetch throttling. A saturating stall-cycle counter is provided for the run-time debug display.

---
 rtl/hazard_ctrl_pkg.sv | 79 +++++++
 rtl/hazard_ring.sv | 41 ++++
 rtl/hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: multicycle FSM states,
// hazard-source priority encoding and the per-register control bundle.
package hazard_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    MC_RUN = 1'b1
  } mc_state_e;

  // Encoded so that a larger value is a higher-priority source.
  typedef enum logic [2:0] {
    SRC_NONE       = 3'd0,
    SRC_THROTTLE   = 3'd1,
    SRC_BRANCH     = 3'd2,
    SRC_LOAD_USE   = 3'd3,
    SRC_MULTICYCLE = 3'd4,
    SRC_MEM_WAIT   = 3'd5
  } hz_src_e;

  typedef struct packed {
    logic pc_stall;
    logic stall_ifid;
    logic flush_ifid;
    logic stall_idexe;
    logic flush_idexe;
    logic stall_exemem;
    logic flush_exemem;
    logic stall_memwb;
    logic flush_memwb;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_RESET = '{
    pc_stall:     1'b1,
    stall_ifid:   1'b0,
    flush_ifid:   1'b1,
    stall_idexe:  1'b0,
    flush_idexe:  1'b1,
    stall_exemem: 1'b0,
    flush_exemem: 1'b1,
    stall_memwb:  1'b0,
    flush_memwb:  1'b1
  };

  // Width of the multicycle down-counter; it only ever holds MC_LAT-1.
  function automatic int mc_cnt_width(input int lat);
    return (lat < 2) ? 1 : $clog2(lat);
  endfunction

  // Each source stalls everything upstream of the first register it flushes.
  function automatic hz_ctrl_t src_ctrl(input hz_src_e src);
    hz_ctrl_t c;
    c = '0;
    case (src)
      SRC_MEM_WAIT: begin
        c.pc_stall     = 1'b1;
        c.stall_ifid   = 1'b1;
        c.stall_idexe  = 1'b1;
        c.stall_exemem = 1'b1;
        c.flush_memwb  = 1'b1;
      end
      SRC_MULTICYCLE: begin
        c.pc_stall     = 1'b1;
        c.stall_ifid   = 1'b1;
        c.stall_idexe  = 1'b1;
        c.flush_exemem = 1'b1;
      end
      SRC_LOAD_USE: begin
        c.pc_stall    = 1'b1;
        c.stall_ifid  = 1'b1;
        c.flush_idexe = 1'b1;
      end
      SRC_BRANCH:   c.flush_ifid = 1'b1;
      SRC_THROTTLE: c.flush_ifid = 1'b1;
      default:      c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hazard_ring.sv
// One-hot rotating ring used to pace instruction fetch; head_o is the
// "fetch allowed" slot. Rotates left only when adv_i is set.
module hazard_ring #(
  parameter int N = 1
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic adv_i,
  output logic head_o
);

  logic [N-1:0] ring_q;
  logic [N-1:0] ring_d;
  logic [N-1:0] ring_rot;

  generate
    if (N == 1) begin : g_single
      assign ring_rot = ring_q;
    end else begin : g_multi
      assign ring_rot = {ring_q[N-2:0], ring_q[N-1]};
    end
  endgenerate

  always_comb begin
    ring_d = ring_q;
    if (adv_i) begin
      ring_d = ring_rot;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      ring_q <= N'(1);
    end else begin
      ring_q <= ring_d;
    end
  end

  assign head_o = ring_q[0];

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: prioritised stall/flush generation
// for memory wait, mult/div, load-use, branch squash and fetch throttling.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W        = 5,
  parameter int MC_LAT       = 4,
  parameter int FETCH_RING   = 1,
  parameter int BRANCH_FLUSH = 0,
  parameter int CNT_W        = 32
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [REG_W-1:0] ID_RS,
  input  logic [REG_W-1:0] ID_RT,
  input  logic             ID_USE_RS,
  input  logic             ID_USE_RT,
  input  logic             EXE_LOAD,
  input  logic [REG_W-1:0] EXE_DEST,
  input  logic             EXE_MC_START,
  input  logic             ID_BRANCH_TAKEN,
  input  logic             MEM_WAIT,
  output logic             PC_STALL,
  output logic             STALL_IFID,
  output logic             FLUSH_IFID,
  output logic             STALL_IDEXE,
  output logic             FLUSH_IDEXE,
  output logic             STALL_EXEMEM,
  output logic             FLUSH_EXEMEM,
  output logic             STALL_MEMWB,
  output logic             FLUSH_MEMWB,
  output logic             MC_BUSY,
  output logic [CNT_W-1:0] STALL_COUNT
);

  localparam int                  MC_CNT_W  = mc_cnt_width(MC_LAT);
  localparam logic [MC_CNT_W-1:0] MC_LOAD   = MC_CNT_W'(MC_LAT - 1);
  localparam bit                  MC_MULTI  = (MC_LAT > 1);
  localparam bit                  BR_SQUASH = (BRANCH_FLUSH != 0);

  mc_state_e           state_q, state_d;
  logic [MC_CNT_W-1:0] mc_cnt_q, mc_cnt_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic     lu;
  logic     mc_start_ok;
  logic     mc_busy;
  logic     ring_head;
  logic     throttle;
  hz_src_e  src;
  hz_ctrl_t ctrl;

  assign lu = EXE_LOAD && (EXE_DEST != '0) &&
              ((ID_USE_RS && (ID_RS == EXE_DEST)) ||
               (ID_USE_RT && (ID_RT == EXE_DEST)));

  // A start under MEM_WAIT is deferred: EXE is frozen and re-presents it.
  assign mc_start_ok = (state_q == IDLE) && EXE_MC_START && !MEM_WAIT;
  assign mc_busy     = (state_q == MC_RUN) || mc_start_ok;
  assign throttle    = !ring_head;

  always_comb begin
    src = SRC_NONE;
    if (MEM_WAIT) begin
      src = SRC_MEM_WAIT;
    end else if (mc_busy) begin
      src = SRC_MULTICYCLE;
    end else if (lu) begin
      src = SRC_LOAD_USE;
    end else if (BR_SQUASH && ID_BRANCH_TAKEN) begin
      src = SRC_BRANCH;
    end else if (throttle) begin
      src = SRC_THROTTLE;
    end
  end

  always_comb begin
    ctrl = src_ctrl(src);
    if (RESET) begin
      ctrl = CTRL_RESET;
    end
  end

  assign PC_STALL     = ctrl.pc_stall;
  assign STALL_IFID   = ctrl.stall_ifid;
  assign FLUSH_IFID   = ctrl.flush_ifid;
  assign STALL_IDEXE  = ctrl.stall_idexe;
  assign FLUSH_IDEXE  = ctrl.flush_idexe;
  assign STALL_EXEMEM = ctrl.stall_exemem;
  assign FLUSH_EXEMEM = ctrl.flush_exemem;
  assign STALL_MEMWB  = ctrl.stall_memwb;
  assign FLUSH_MEMWB  = ctrl.flush_memwb;
  assign MC_BUSY      = mc_busy;
  assign STALL_COUNT  = stall_cnt_q;

  // Multicycle FSM: the start cycle counts as the first busy cycle.
  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    case (state_q)
      IDLE: begin
        if (mc_start_ok && MC_MULTI) begin
          state_d  = MC_RUN;
          mc_cnt_d = MC_LOAD;
        end
      end
      MC_RUN: begin
        if (!MEM_WAIT) begin
          if (mc_cnt_q == MC_CNT_W'(1)) begin
            state_d  = IDLE;
            mc_cnt_d = '0;
          end else begin
            mc_cnt_d = mc_cnt_q - MC_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d  = IDLE;
        mc_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (PC_STALL && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q     <= IDLE;
      mc_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mc_cnt_q    <= mc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  hazard_ring #(
    .N (FETCH_RING)
  ) u_ring (
    .clk_i  (CLOCK),
    .srst_i (RESET),
    .adv_i  (!PC_STALL),
    .head_o (ring_head)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: instance A (MC_LAT=4, branch squash,
// 4-bit counter) and instance B (FETCH_RING=5, delay-slot) share inputs.
module tb_hazard_ctrl;

  // Control word layout: {busy, pc, s_ifid, f_ifid, s_idexe, f_idexe,
  //                       s_exemem, f_exemem, s_memwb, f_memwb}
  localparam logic [9:0] C_NONE = 10'b0000000000;
  localparam logic [9:0] C_LU   = 10'b0110010000;
  localparam logic [9:0] C_MC   = 10'b1110100100;
  localparam logic [9:0] C_MW   = 10'b0110101001;
  localparam logic [9:0] C_MWB  = 10'b1110101001;
  localparam logic [9:0] C_FIF  = 10'b0001000000;
  localparam logic [9:0] C_RST  = 10'b0101010101;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, exe_dest;
  logic       use_rs, use_rt, exe_load, mc_start, br, mem_wait;

  logic a_pc, a_sifid, a_fifid, a_sidexe, a_fidexe, a_sexemem, a_fexemem, a_smemwb, a_fmemwb, a_busy;
  logic b_pc, b_sifid, b_fifid, b_sidexe, b_fidexe, b_sexemem, b_fexemem, b_smemwb, b_fmemwb, b_busy;
  logic [3:0]  a_cnt;
  logic [31:0] b_cnt;

  wire [9:0] a_ctl = {a_busy, a_pc, a_sifid, a_fifid, a_sidexe, a_fidexe, a_sexemem, a_fexemem, a_smemwb, a_fmemwb};
  wire [9:0] b_ctl = {b_busy, b_pc, b_sifid, b_fifid, b_sidexe, b_fidexe, b_sexemem, b_fexemem, b_smemwb, b_fmemwb};

  typedef struct {
    string      tag;
    logic [9:0] a_exp;
    logic [9:0] b_exp;
    bit         in_rst;
    bit         chk_b;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt_a = 0;
  int   exp_cnt_b = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(5), .MC_LAT(4), .FETCH_RING(1), .BRANCH_FLUSH(1), .CNT_W(4)) u_a (
    .CLOCK(clk), .RESET(rst), .ID_RS(id_rs), .ID_RT(id_rt), .ID_USE_RS(use_rs), .ID_USE_RT(use_rt),
    .EXE_LOAD(exe_load), .EXE_DEST(exe_dest), .EXE_MC_START(mc_start), .ID_BRANCH_TAKEN(br),
    .MEM_WAIT(mem_wait), .PC_STALL(a_pc), .STALL_IFID(a_sifid), .FLUSH_IFID(a_fifid),
    .STALL_IDEXE(a_sidexe), .FLUSH_IDEXE(a_fidexe), .STALL_EXEMEM(a_sexemem), .FLUSH_EXEMEM(a_fexemem),
    .STALL_MEMWB(a_smemwb), .FLUSH_MEMWB(a_fmemwb), .MC_BUSY(a_busy), .STALL_COUNT(a_cnt));

  hazard_ctrl #(.REG_W(5), .MC_LAT(4), .FETCH_RING(5), .BRANCH_FLUSH(0), .CNT_W(32)) u_b (
    .CLOCK(clk), .RESET(rst), .ID_RS(id_rs), .ID_RT(id_rt), .ID_USE_RS(use_rs), .ID_USE_RT(use_rt),
    .EXE_LOAD(exe_load), .EXE_DEST(exe_dest), .EXE_MC_START(mc_start), .ID_BRANCH_TAKEN(br),
    .MEM_WAIT(mem_wait), .PC_STALL(b_pc), .STALL_IFID(b_sifid), .FLUSH_IFID(b_fifid),
    .STALL_IDEXE(b_sidexe), .FLUSH_IDEXE(b_fidexe), .STALL_EXEMEM(b_sexemem), .FLUSH_EXEMEM(b_fexemem),
    .STALL_MEMWB(b_smemwb), .FLUSH_MEMWB(b_fmemwb), .MC_BUSY(b_busy), .STALL_COUNT(b_cnt));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    id_rs = 5'd0; id_rt = 5'd0; use_rs = 1'b0; use_rt = 1'b0;
    exe_load = 1'b0; exe_dest = 5'd0; mc_start = 1'b0; br = 1'b0; mem_wait = 1'b0;
  endtask

  // Push the expectation for the cycle being driven, compare mid-cycle.
  task automatic step(input string tag, input logic [9:0] ea, input bit chk_b, input logic [9:0] eb);
    exp_t e;
    exp_t got;
    logic [9:0] mask;
    e.tag = tag; e.a_exp = ea; e.b_exp = eb; e.in_rst = rst; e.chk_b = chk_b;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      got  = sb.pop_front();
      mask = got.in_rst ? 10'h1FF : 10'h3FF;
      check({got.tag, "_a_ctl"}, 32'(a_ctl & mask), 32'(got.a_exp & mask));
      check({got.tag, "_a_cnt"}, 32'(a_cnt), 32'(exp_cnt_a));
      if (got.chk_b) begin
        check({got.tag, "_b_ctl"}, 32'(b_ctl & mask), 32'(got.b_exp & mask));
        check({got.tag, "_b_cnt"}, b_cnt, 32'(exp_cnt_b));
      end
      $display("TXN %-10s a_ctl=%b b_ctl=%b a_cnt=%0d", got.tag, a_ctl, b_ctl, a_cnt);
    end
    @(posedge clk);
    #1;
    if (e.in_rst) begin
      exp_cnt_a = 0;
      exp_cnt_b = 0;
    end else if (ea[8]) begin
      if (exp_cnt_a < 15) exp_cnt_a++;
      exp_cnt_b++;
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    @(posedge clk);
    #1;
    step("rst", C_RST, 1'b1, C_RST);
    rst = 1'b0;
    step("idle", C_NONE, 1'b0, C_NONE);

    // Load-use via rs, then the load has moved on
    exe_load = 1'b1; exe_dest = 5'd8; id_rs = 5'd8; use_rs = 1'b1;
    step("lu_rs", C_LU, 1'b0, C_NONE);
    idle_in();
    step("lu_gone", C_NONE, 1'b0, C_NONE);
    exe_load = 1'b1; exe_dest = 5'd0; id_rs = 5'd0; use_rs = 1'b1;
    step("lu_r0", C_NONE, 1'b0, C_NONE);
    idle_in();
    exe_load = 1'b1; exe_dest = 5'd5; id_rt = 5'd5; use_rt = 1'b1;
    step("lu_rt", C_LU, 1'b0, C_NONE);
    use_rt = 1'b0;
    step("lu_rt_unused", C_NONE, 1'b0, C_NONE);

    // Branch squash, and branch masked by load-use
    idle_in(); br = 1'b1;
    step("br", C_FIF, 1'b0, C_NONE);
    exe_load = 1'b1; exe_dest = 5'd3; id_rs = 5'd3; use_rs = 1'b1;
    step("br_lu", C_LU, 1'b0, C_NONE);

    // Multicycle op pulsed: four busy cycles
    idle_in(); mc_start = 1'b1;
    step("mc_start", C_MC, 1'b0, C_NONE);
    mc_start = 1'b0;
    for (int i = 0; i < 3; i++) step("mc_run", C_MC, 1'b0, C_NONE);
    step("mc_done", C_NONE, 1'b0, C_NONE);

    // Start held while EXE is frozen is ignored until IDLE
    mc_start = 1'b1;
    for (int i = 0; i < 4; i++) step("mc_hold", C_MC, 1'b0, C_NONE);
    mc_start = 1'b0;
    step("mc_hold_done", C_NONE, 1'b0, C_NONE);

    // Memory wait inside MC_RUN stretches the window to six cycles
    mc_start = 1'b1;
    step("mcw_start", C_MC, 1'b0, C_NONE);
    mc_start = 1'b0;
    step("mcw_run", C_MC, 1'b0, C_NONE);
    mem_wait = 1'b1;
    step("mcw_wait", C_MWB, 1'b0, C_NONE);
    step("mcw_wait", C_MWB, 1'b0, C_NONE);
    mem_wait = 1'b0;
    step("mcw_run", C_MC, 1'b0, C_NONE);
    step("mcw_run", C_MC, 1'b0, C_NONE);
    step("mcw_done", C_NONE, 1'b0, C_NONE);

    // Memory wait defers a start; it masks load-use and branch too
    mc_start = 1'b1; mem_wait = 1'b1;
    step("defer", C_MW, 1'b0, C_NONE);
    mem_wait = 1'b0;
    step("defer_go", C_MC, 1'b0, C_NONE);
    mc_start = 1'b0;
    for (int i = 0; i < 3; i++) step("defer_run", C_MC, 1'b0, C_NONE);
    mem_wait = 1'b1; br = 1'b1; exe_load = 1'b1; exe_dest = 5'd9; id_rt = 5'd9; use_rt = 1'b1;
    step("mw_all", C_MW, 1'b0, C_NONE);

    // Reset in the middle of a multicycle op
    idle_in(); mc_start = 1'b1;
    step("rmc_start", C_MC, 1'b0, C_NONE);
    mc_start = 1'b0;
    step("rmc_run", C_MC, 1'b0, C_NONE);
    rst = 1'b1;
    step("rmc_rst", C_RST, 1'b1, C_RST);
    rst = 1'b0;

    // Throttle on B: 0,1,1,1,1 with a taken branch not squashed on B
    br = 1'b1;
    step("thr0_br", C_FIF, 1'b1, C_NONE);
    br = 1'b0;
    for (int i = 0; i < 4; i++) step("thr", C_NONE, 1'b1, C_FIF);
    step("thr0", C_NONE, 1'b1, C_NONE);
    step("thr", C_NONE, 1'b1, C_FIF);
    exe_load = 1'b1; exe_dest = 5'd7; id_rs = 5'd7; use_rs = 1'b1;
    step("thr_lu", C_LU, 1'b1, C_LU);
    idle_in();
    for (int i = 0; i < 3; i++) step("thr_frz", C_NONE, 1'b1, C_FIF);
    step("thr_frz0", C_NONE, 1'b1, C_NONE);

    // Counter saturation on the 4-bit instance
    exe_load = 1'b1; exe_dest = 5'd2; id_rs = 5'd2; use_rs = 1'b1;
    for (int i = 0; i < 17; i++) step("sat_lu", C_LU, 1'b1, C_LU);
    idle_in();
    step("sat_end", C_NONE, 1'b0, C_NONE);
    check("sat_value", 32'(a_cnt), 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
